// File: rtl/mac_tile_pkg.sv
// mac_tile_pkg
//   Shared definitions for the mac_tile_dbuf processing element:
//   - bit positions of the instruction word
//   - the decoded operation type and the precedence decoder
//   - the overflow classifier used by mac_sat for saturation
//   No ports; imported by mac_sat and mac_tile_dbuf.
package mac_tile_pkg;

  localparam int INST_KERNLD   = 0;
  localparam int INST_WS_EXEC  = 1;
  localparam int INST_OS_EXEC  = 2;
  localparam int INST_OS_FLUSH = 3;
  localparam int INST_SWAP     = 4;
  localparam int INST_BITS     = 5;

  // One operation acts per cycle; OP_NOP covers an all-zero low nibble.
  typedef enum logic [2:0] {
    OP_NOP,
    OP_KERNLD,
    OP_WS_EXEC,
    OP_OS_FLUSH,
    OP_OS_EXEC
  } op_e;

  // Result of checking a (psum_bw+1)-bit sum against the psum range.
  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_e;

  // Precedence: kernld > ws_exec > os_flush > os_exec.
  function automatic op_e decode_op(input logic [3:0] bits);
    op_e op;
    op = OP_NOP;
    if (bits[INST_KERNLD])        op = OP_KERNLD;
    else if (bits[INST_WS_EXEC])  op = OP_WS_EXEC;
    else if (bits[INST_OS_FLUSH]) op = OP_OS_FLUSH;
    else if (bits[INST_OS_EXEC])  op = OP_OS_EXEC;
    return op;
  endfunction

  // More than one of the four operation bits set.
  function automatic logic is_multi_hot(input logic [3:0] bits);
    return (bits & (bits - 4'd1)) != 4'd0;
  endfunction

  // top/next are the two most significant bits of a sum that carries one
  // guard bit above the psum width. Signed overflow shows as top != next
  // (top tells the direction); unsigned overflow shows as a carry in top.
  function automatic sat_e classify_sum(input logic top, input logic next,
                                        input logic signed_mode,
                                        input logic sat_mode);
    sat_e kind;
    kind = SAT_NONE;
    if (sat_mode) begin
      if (signed_mode) begin
        if (top != next) kind = top ? SAT_LO : SAT_HI;
      end else begin
        if (top) kind = SAT_HI;
      end
    end
    return kind;
  endfunction

endpackage

// File: rtl/mac_sat.sv
// mac_sat
//   Combinational multiply-accumulate: out = ext(a*b) + c, with the product
//   sign- or zero-extended per SIGNED and the sum either clamped (SAT=1) or
//   wrapped modulo 2^psum_bw (SAT=0).
//   Ports:
//     a, b  [bw-1:0]       operands
//     c     [psum_bw-1:0]  addend (partial sum / accumulator)
//     out   [psum_bw-1:0]  result
module mac_sat
  import mac_tile_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SIGNED  = 0,
  parameter int SAT     = 0
) (
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] out
);

  localparam int PW    = 2 * bw;
  localparam int EXT_W = psum_bw + 1 - PW;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic [psum_bw:0] prod_ext;
  logic [psum_bw:0] c_ext;
  logic [psum_bw:0] sum;
  logic             sign_mode;
  sat_e             sat_kind;

  // Operands are widened to the product width first so the multiply is a
  // plain same-width operation; the low 2*bw bits are the exact product in
  // both signed and unsigned modes. The sum keeps one guard bit so that
  // overflow can be detected before clamping.
  always_comb begin
    sign_mode = (SIGNED != 0);
    a_ext     = {{bw{sign_mode & a[bw-1]}}, a};
    b_ext     = {{bw{sign_mode & b[bw-1]}}, b};
    prod      = a_ext * b_ext;
    prod_ext  = {{EXT_W{sign_mode & prod[PW-1]}}, prod};
    c_ext     = {sign_mode & c[psum_bw-1], c};
    sum       = prod_ext + c_ext;
    sat_kind  = classify_sum(sum[psum_bw], sum[psum_bw-1], sign_mode, SAT != 0);
    out       = sum[psum_bw-1:0];
    case (sat_kind)
      SAT_HI:  out = sign_mode ? {1'b0, {(psum_bw-1){1'b1}}} : {psum_bw{1'b1}};
      SAT_LO:  out = sign_mode ? {1'b1, {(psum_bw-1){1'b0}}} : {psum_bw{1'b0}};
      default: out = sum[psum_bw-1:0];
    endcase
  end

endmodule

// File: rtl/mac_tile_dbuf.sv
// mac_tile_dbuf
//   Systolic-array MAC tile with two dataflows:
//   - weight-stationary: double-buffered weight store; the shadow bank is a
//     one-entry stage of the column's weight shift chain, ws_swap flips the
//     active bank at the end of the cycle.
//   - output-stationary: NUM_ACC accumulators filled round-robin; a product
//     latched by os_exec is accumulated one cycle later (pending accumulate);
//     os_flush shifts the accumulators south as a chain.
//   Ports:
//     clk, reset  clock, synchronous active-high reset
//     in_w        activation from west
//     in_n        weight (low bw bits) or psum from north
//     inst_w      instruction from west
//     out_s       southward weight / psum / flush data
//     out_e       eastward activation (registered a_q)
//     inst_e      registered instruction forwarded east
//     inst_err    sticky flag: multi-hot operation bits were seen
module mac_tile_dbuf
  import mac_tile_pkg::*;
#(
  parameter int bw         = 4,
  parameter int psum_bw    = 16,
  parameter int NUM_ACC    = 2,
  parameter int SIGNED     = 0,
  parameter int SAT        = 0,
  parameter int inst_width = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [bw-1:0]         in_w,
  input  logic [psum_bw-1:0]    in_n,
  input  logic [inst_width-1:0] inst_w,
  output logic [psum_bw-1:0]    out_s,
  output logic [bw-1:0]         out_e,
  output logic [inst_width-1:0] inst_e,
  output logic                  inst_err
);

  localparam int ACC_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_ACC - 1);

  logic [inst_width-1:0] inst_q, inst_d;
  logic                  inst_err_q, inst_err_d;
  logic [bw-1:0]         a_q, a_d;
  logic [bw-1:0]         wbank_q [2];
  logic [bw-1:0]         wbank_d [2];
  logic                  bank_sel_q, bank_sel_d;
  logic [bw-1:0]         b_os_q, b_os_d;
  logic [psum_bw-1:0]    c_q   [NUM_ACC];
  logic [psum_bw-1:0]    c_d   [NUM_ACC];
  logic [psum_bw-1:0]    c_upd [NUM_ACC];
  logic [ACC_W-1:0]      acc_ptr_q, acc_ptr_d;
  logic                  op_valid_q, op_valid_d;
  logic [ACC_W-1:0]      op_ptr_q, op_ptr_d;

  op_e                   op;
  logic                  swap;
  logic [psum_bw-1:0]    ws_result;
  logic [psum_bw-1:0]    os_result;
  logic [psum_bw-1:0]    os_c;

  mac_sat #(
    .bw(bw), .psum_bw(psum_bw), .SIGNED(SIGNED), .SAT(SAT)
  ) u_ws_mac (
    .a(a_q), .b(wbank_q[bank_sel_q]), .c(c_q[0]), .out(ws_result)
  );

  mac_sat #(
    .bw(bw), .psum_bw(psum_bw), .SIGNED(SIGNED), .SAT(SAT)
  ) u_os_mac (
    .a(a_q), .b(b_os_q), .c(os_c), .out(os_result)
  );

  // Instruction decode and the accumulator view with the pending
  // accumulate already applied; flush and the c register update both
  // build on c_upd so a product issued just before a flush is not lost.
  always_comb begin
    op    = decode_op(inst_q[3:0]);
    swap  = inst_q[INST_SWAP];
    os_c  = c_q[op_ptr_q];
    c_upd = c_q;
    if (op_valid_q) c_upd[op_ptr_q] = os_result;
  end

  // Next-state and southward output for the decoded operation.
  always_comb begin
    inst_d     = inst_w;
    inst_err_d = inst_err_q | is_multi_hot(inst_q[3:0]);
    a_d        = a_q;
    wbank_d    = wbank_q;
    bank_sel_d = bank_sel_q;
    b_os_d     = b_os_q;
    c_d        = c_upd;
    acc_ptr_d  = acc_ptr_q;
    op_valid_d = 1'b0;
    op_ptr_d   = op_ptr_q;
    out_s      = {{(psum_bw-bw){1'b0}}, b_os_q};

    case (op)
      OP_KERNLD: begin
        out_s                = {{(psum_bw-bw){1'b0}}, wbank_q[~bank_sel_q]};
        wbank_d[~bank_sel_q] = in_n[bw-1:0];
      end
      OP_WS_EXEC: begin
        a_d   = in_w;
        out_s = ws_result;
        // A pending accumulate into c[0] takes priority over the psum load.
        if (!(op_valid_q && (op_ptr_q == '0))) c_d[0] = in_n;
      end
      OP_OS_EXEC: begin
        a_d        = in_w;
        b_os_d     = in_n[bw-1:0];
        op_valid_d = 1'b1;
        op_ptr_d   = acc_ptr_q;
        acc_ptr_d  = (acc_ptr_q == ACC_LAST) ? '0 : acc_ptr_q + 1'b1;
      end
      OP_OS_FLUSH: begin
        out_s = c_upd[NUM_ACC-1];
        for (int k = 1; k < NUM_ACC; k++) c_d[k] = c_upd[k-1];
        c_d[0]    = in_n;
        acc_ptr_d = '0;
      end
      default: begin
      end
    endcase

    // The swap is applied last so same-cycle kernld/ws_exec saw the old bank.
    if (swap) bank_sel_d = ~bank_sel_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q     <= '0;
      inst_err_q <= 1'b0;
      a_q        <= '0;
      wbank_q[0] <= '0;
      wbank_q[1] <= '0;
      bank_sel_q <= 1'b0;
      b_os_q     <= '0;
      for (int k = 0; k < NUM_ACC; k++) c_q[k] <= '0;
      acc_ptr_q  <= '0;
      op_valid_q <= 1'b0;
      op_ptr_q   <= '0;
    end else begin
      inst_q     <= inst_d;
      inst_err_q <= inst_err_d;
      a_q        <= a_d;
      wbank_q    <= wbank_d;
      bank_sel_q <= bank_sel_d;
      b_os_q     <= b_os_d;
      c_q        <= c_d;
      acc_ptr_q  <= acc_ptr_d;
      op_valid_q <= op_valid_d;
      op_ptr_q   <= op_ptr_d;
    end
  end

  assign out_e    = a_q;
  assign inst_e   = inst_q;
  assign inst_err = inst_err_q;

endmodule

// File: tb/tb_mac_tile_dbuf.sv
// tb_mac_tile_dbuf
//   Scoreboard bench for mac_tile_dbuf. The stimulus process issues one
//   instruction per cycle (operand data follows one cycle behind, matching
//   the tile's registered instruction) and queues hand-computed expectations
//   tagged with the cycle in which they must hold. A monitor on the falling
//   edge pops and compares due entries. Two extra tiles configured with
//   signed 8-bit psums (saturating and wrapping) cover the clamp behaviour.
module tb_mac_tile_dbuf;

  localparam logic [4:0] I_NOP   = 5'b00000;
  localparam logic [4:0] I_KLD   = 5'b00001;
  localparam logic [4:0] I_WS    = 5'b00010;
  localparam logic [4:0] I_OS    = 5'b00100;
  localparam logic [4:0] I_FL    = 5'b01000;
  localparam logic [4:0] I_SWAP  = 5'b10000;

  localparam int SIG_OUT_S    = 0;
  localparam int SIG_OUT_E    = 1;
  localparam int SIG_INST_E   = 2;
  localparam int SIG_INST_ERR = 3;
  localparam int SIG_SAT_OUT  = 4;
  localparam int SIG_WRAP_OUT = 5;

  typedef struct {
    int          due;
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_w = '0;
  logic [15:0] in_n = '0;
  logic [4:0]  inst_w = '0;

  logic [15:0] out_s;
  logic [3:0]  out_e;
  logic [4:0]  inst_e;
  logic        inst_err;

  logic [7:0]  sat_out_s, wrap_out_s;
  logic [3:0]  sat_out_e, wrap_out_e;
  logic [4:0]  sat_inst_e, wrap_inst_e;
  logic        sat_inst_err, wrap_inst_err;
  logic [7:0]  in_n8;

  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  exp_t        sb[$];
  logic [3:0]  prev_w = '0;
  logic [15:0] prev_n = '0;

  assign in_n8 = in_n[7:0];

  mac_tile_dbuf dut (
    .clk(clk), .reset(reset), .in_w(in_w), .in_n(in_n), .inst_w(inst_w),
    .out_s(out_s), .out_e(out_e), .inst_e(inst_e), .inst_err(inst_err)
  );

  mac_tile_dbuf #(
    .bw(4), .psum_bw(8), .NUM_ACC(1), .SIGNED(1), .SAT(1), .inst_width(5)
  ) dut_sat (
    .clk(clk), .reset(reset), .in_w(in_w), .in_n(in_n8), .inst_w(inst_w),
    .out_s(sat_out_s), .out_e(sat_out_e), .inst_e(sat_inst_e),
    .inst_err(sat_inst_err)
  );

  mac_tile_dbuf #(
    .bw(4), .psum_bw(8), .NUM_ACC(1), .SIGNED(1), .SAT(0), .inst_width(5)
  ) dut_wrap (
    .clk(clk), .reset(reset), .in_w(in_w), .in_n(in_n8), .inst_w(inst_w),
    .out_s(wrap_out_s), .out_e(wrap_out_e), .inst_e(wrap_inst_e),
    .inst_err(wrap_inst_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    case (e.sig)
      SIG_OUT_S:    act = out_s;
      SIG_OUT_E:    act = {12'd0, out_e};
      SIG_INST_E:   act = {11'd0, inst_e};
      SIG_INST_ERR: act = {15'd0, inst_err};
      SIG_SAT_OUT:  act = {8'd0, sat_out_s};
      SIG_WRAP_OUT: act = {8'd0, wrap_out_s};
      default:      act = 'x;
    endcase
    tests_run++;
    if (act !== e.exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               e.name, act, e.exp, cyc);
    end
  endtask

  // Monitor: service every expectation that is due in this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: not sampled, due cycle %0d now %0d",
                 sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Offset 1 = the cycle in which the instruction just issued acts.
  task automatic expectAt(input int offset, input int sig,
                          input logic [15:0] val, input string name);
    exp_t e;
    e.due  = cyc + offset;
    e.sig  = sig;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Issue an instruction; its operands are driven one cycle later.
  task automatic applyStimulus(input logic [4:0] inst, input logic [3:0] w,
                               input logic [15:0] n);
    @(posedge clk);
    #1;
    inst_w = inst;
    in_w   = prev_w;
    in_n   = prev_n;
    prev_w = w;
    prev_n = n;
  endtask

  task automatic doReset(input string tag);
    applyStimulus(I_NOP, 4'd0, 16'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    inst_w = 5'($urandom);
    in_w   = 4'($urandom);
    in_n   = 16'($urandom);
    @(posedge clk);
    #1;
    inst_w = 5'($urandom);
    in_w   = 4'($urandom);
    in_n   = 16'($urandom);
    @(posedge clk);
    #1;
    expectAt(0, SIG_OUT_S,    16'd0, {tag, "_out_s"});
    expectAt(0, SIG_OUT_E,    16'd0, {tag, "_out_e"});
    expectAt(0, SIG_INST_E,   16'd0, {tag, "_inst_e"});
    expectAt(0, SIG_INST_ERR, 16'd0, {tag, "_inst_err"});
    reset  = 1'b0;
    inst_w = I_NOP;
    in_w   = '0;
    in_n   = '0;
    prev_w = '0;
    prev_n = '0;
  endtask

  initial begin
    doReset("reset0");

    // Weight load and execute: shadow chain, swap, 2*5+10.
    applyStimulus(I_KLD, 4'd0, 16'd3);
    applyStimulus(I_KLD, 4'd0, 16'd5);
    expectAt(1, SIG_OUT_S, 16'd3, "kernld_shift_out");
    applyStimulus(I_SWAP, 4'd0, 16'd0);
    applyStimulus(I_WS, 4'd2, 16'd10);
    applyStimulus(I_WS, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S,  16'd20, "ws_exec_mac");
    expectAt(1, SIG_OUT_E,  16'd2,  "ws_out_e");
    expectAt(1, SIG_INST_E, 16'd2,  "ws_inst_e");

    // Double buffer: kernel 7 loads behind the active weight 5.
    applyStimulus(I_WS, 4'd1, 16'd0);
    applyStimulus(I_KLD, 4'd0, 16'd7);
    expectAt(1, SIG_OUT_S, 16'd0, "kernld_shadow_empty");
    applyStimulus(I_WS, 4'd1, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd5, "dbuf_active_hold_a");
    applyStimulus(I_WS, 4'd1, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd5, "dbuf_active_hold_b");
    applyStimulus(I_WS | I_SWAP, 4'd1, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd5, "swap_uses_preswap");
    applyStimulus(I_WS, 4'd1, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd7, "dbuf_after_swap");
    expectAt(1, SIG_OUT_E, 16'd1, "dbuf_out_e");

    // Output-stationary interleave over two accumulators.
    doReset("reset1");
    applyStimulus(I_OS, 4'd1, 16'd2);
    applyStimulus(I_OS, 4'd3, 16'd4);
    expectAt(1, SIG_OUT_S, 16'd2, "os_weight_pass");
    applyStimulus(I_OS, 4'd5, 16'd6);
    applyStimulus(I_OS, 4'd7, 16'd8);
    applyStimulus(I_FL, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd68, "flush_acc1");
    applyStimulus(I_FL, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd32, "flush_acc0");
    applyStimulus(I_OS, 4'd2, 16'd3);
    applyStimulus(I_FL, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd0, "acc_ptr_reset_a");
    applyStimulus(I_FL, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd6, "acc_ptr_reset_b");

    // Reset while a product is pending.
    applyStimulus(I_OS, 4'd3, 16'd3);
    doReset("reset_pending");

    // Signed saturation vs wrap: (-8)*(-8) twice into one accumulator.
    applyStimulus(I_OS, 4'd8, 16'd8);
    applyStimulus(I_OS, 4'd8, 16'd8);
    applyStimulus(I_FL, 4'd0, 16'd0);
    expectAt(1, SIG_SAT_OUT,  16'h007F, "sat_clamp_hi");
    expectAt(1, SIG_WRAP_OUT, 16'h0080, "wrap_modulo");

    // Illegal kernld+ws_exec: only the kernld acts, error flag is sticky.
    applyStimulus(5'b00011, 4'd4, 16'd9);
    expectAt(1, SIG_OUT_S,    16'd0, "illegal_kernld_out");
    expectAt(1, SIG_INST_E,   16'd3, "illegal_inst_e");
    expectAt(1, SIG_INST_ERR, 16'd0, "illegal_err_not_yet");
    expectAt(2, SIG_INST_ERR, 16'd1, "illegal_err_set");
    expectAt(2, SIG_OUT_E,    16'd8, "illegal_no_ws_exec");
    applyStimulus(I_SWAP, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd8, "nop_passes_b_os");
    applyStimulus(I_WS, 4'd0, 16'd0);
    expectAt(1, SIG_OUT_S, 16'd72, "illegal_shadow_loaded");
    applyStimulus(I_NOP, 4'd0, 16'd0);
    applyStimulus(I_NOP, 4'd0, 16'd0);
    expectAt(1, SIG_INST_ERR, 16'd1, "inst_err_sticky");
    doReset("reset_clears_err");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: expectation never serviced", sb[0].name);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
